button_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the Pong game logic.
- Takes raw, asynchronous, normally-closed paddle buttons and produces clean signals for the paddle-movement logic:
  - synchronized, debounced "pressed" levels;
  - one-clock press/release pulses;
  - auto-repeat pulses.
- Also produces sticky event flags with an acknowledge handshake, so the slow game-tick logic never misses a one-clock pulse.
- Runs entirely in the fast `clk` domain.

---
 rtl/button_conditioner.sv | 153 +++++++++++++++
 tb/tb_button_conditioner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronize, debounce and auto-repeat raw paddle buttons
// Produces clean levels, one-clock pulses and sticky acknowledged event flags.
module button_conditioner #(
  parameter int NUM_BUTTONS     = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int REPEAT_DELAY    = 4194304,
  parameter int REPEAT_PERIOD   = 1048576
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] repeat_pulse,
  output logic [NUM_BUTTONS-1:0] event_pending,
  input  logic [NUM_BUTTONS-1:0] event_ack
);

  localparam logic REL = (ACTIVE_LOW != 0);
  localparam int   RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int   DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int   RW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [DW-1:0] DLAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RFIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RLATER = RW'(REPEAT_PERIOD - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("button_conditioner: REPEAT_PERIOD must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

  logic [NUM_BUTTONS-1:0] sync1, sync2, s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= {NUM_BUTTONS{REL}};
      sync2 <= {NUM_BUTTONS{REL}};
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ {NUM_BUTTONS{REL}};

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    state_t        state, stateNext;
    logic [DW-1:0] dcnt, dcntNext;
    logic [RW-1:0] rcnt, rcntNext;
    logic          repeating, repeatingNext;
    logic          pressedQ, pressedNext;
    logic          pressP, pressPNext, relP, relPNext, repP, repPNext;
    logic          pend, pendNext;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        dcnt      <= '0;
        rcnt      <= '0;
        repeating <= 1'b0;
        pressedQ  <= 1'b0;
        pressP    <= 1'b0;
        relP      <= 1'b0;
        repP      <= 1'b0;
        pend      <= 1'b0;
      end else begin
        state     <= stateNext;
        dcnt      <= dcntNext;
        rcnt      <= rcntNext;
        repeating <= repeatingNext;
        pressedQ  <= pressedNext;
        pressP    <= pressPNext;
        relP      <= relPNext;
        repP      <= repPNext;
        pend      <= pendNext;
      end
    end

    always_comb begin
      stateNext     = state;
      dcntNext      = dcnt;
      rcntNext      = rcnt;
      repeatingNext = repeating;
      pressedNext   = pressedQ;
      pressPNext    = 1'b0;
      relPNext      = 1'b0;
      repPNext      = 1'b0;
      case (state)
        IDLE: begin
          if (s[i]) begin
            stateNext = DB_PRESS;
            dcntNext  = '0;
          end
        end
        DB_PRESS: begin
          if (!s[i]) begin
            stateNext = IDLE;
          end else if (dcnt == DLAST) begin
            stateNext     = HELD;
            pressedNext   = 1'b1;
            pressPNext    = 1'b1;
            rcntNext      = '0;
            repeatingNext = 1'b0;
          end else begin
            dcntNext = dcnt + 1'b1;
          end
        end
        HELD: begin
          if (!s[i]) begin
            stateNext = DB_RELEASE;
            dcntNext  = '0;
          end else if (REPEAT_DELAY != 0) begin
            // First pulse waits the full delay; later ones count from zero again over the period.
            if (rcnt == (repeating ? RLATER : RFIRST)) begin
              repPNext      = 1'b1;
              rcntNext      = '0;
              repeatingNext = 1'b1;
            end else begin
              rcntNext = rcnt + 1'b1;
            end
          end
        end
        DB_RELEASE: begin
          if (s[i]) begin
            stateNext = HELD;
          end else if (dcnt == DLAST) begin
            stateNext   = IDLE;
            pressedNext = 1'b0;
            relPNext    = 1'b1;
          end else begin
            dcntNext = dcnt + 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
      // A new event always wins over an acknowledge arriving in the same cycle.
      pendNext = (pressP | repP) ? 1'b1 : (event_ack[i] ? 1'b0 : pend);
    end

    assign pressed[i]       = pressedQ;
    assign press_pulse[i]   = pressP;
    assign release_pulse[i] = relP;
    assign repeat_pulse[i]  = repP;
    assign event_pending[i] = pend;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed bench for button_conditioner
// Reference model tracks run lengths of synchronized samples and held-tick counts.
module tb_button_conditioner;

  localparam int DEB   = 4;
  localparam int DELAY = 10;
  localparam int PER   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] btn_raw = 2'b11;
  logic [1:0] event_ack = 2'b00;
  logic [1:0] pressed, press_pulse, release_pulse, repeat_pulse, event_pending;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BUTTONS(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .event_pending(event_pending), .event_ack(event_ack)
  );

  logic [1:0] mRaw1, mRaw2, sNow;
  logic [1:0] mPressed, mPressP, mRelP, mRepP, mPend;
  int         mRun [2];
  int         mTicks [2];

  // pressed flips after DEB+1 consecutive disagreeing samples; repeats fire on held ticks DELAY, DELAY+PER, ...
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mRaw1 = 2'b11; mRaw2 = 2'b11;
      mPressed = 0; mPressP = 0; mRelP = 0; mRepP = 0; mPend = 0;
      for (int c = 0; c < 2; c++) begin mRun[c] = 0; mTicks[c] = 0; end
    end else begin
      sNow = ~mRaw2;
      for (int c = 0; c < 2; c++) begin
        mPend[c] = (mPressP[c] | mRepP[c]) ? 1'b1 : (event_ack[c] ? 1'b0 : mPend[c]);
        mPressP[c] = 1'b0; mRelP[c] = 1'b0; mRepP[c] = 1'b0;
        if (sNow[c] != mPressed[c]) begin
          mRun[c]++;
          if (mRun[c] == DEB + 1) begin
            mPressed[c] = ~mPressed[c];
            mRun[c] = 0;
            if (mPressed[c]) begin mPressP[c] = 1'b1; mTicks[c] = 0; end
            else mRelP[c] = 1'b1;
          end
        end else begin
          if (mPressed[c] && mRun[c] == 0) begin
            mTicks[c]++;
            if (mTicks[c] >= DELAY && (mTicks[c] - DELAY) % PER == 0) mRepP[c] = 1'b1;
          end
          mRun[c] = 0;
        end
      end
      mRaw2 = mRaw1;
      mRaw1 = btn_raw;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_pressed", {30'd0, pressed}, {30'd0, mPressed});
    chk("model_press_pulse", {30'd0, press_pulse}, {30'd0, mPressP});
    chk("model_release_pulse", {30'd0, release_pulse}, {30'd0, mRelP});
    chk("model_repeat_pulse", {30'd0, repeat_pulse}, {30'd0, mRepP});
    chk("model_event_pending", {30'd0, event_pending}, {30'd0, mPend});
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chkAllZero(input string nm);
    chk(nm, {22'd0, pressed, press_pulse, release_pulse, repeat_pulse, event_pending}, 32'd0);
  endtask

  logic [30:0] repMask;
  int          left [2];
  int          r;

  initial begin
    repMask = 31'h12492400;
    #1 rst_n = 1'b0;
    edges(3);
    chkAllZero("reset_outputs");
    #1 rst_n = 1'b1; btn_raw = 2'b10;
    edges(6);
    chk("press_latency_early", {30'd0, pressed}, 32'd0);
    edges(1);
    chk("press_rise", {30'd0, pressed}, 32'd1);
    chk("press_pulse_rise", {30'd0, press_pulse}, 32'd1);
    edges(1);
    chk("press_pulse_one_cycle", {30'd0, press_pulse}, 32'd0);
    chk("pending_after_press", {30'd0, event_pending}, 32'd1);
    #1 event_ack = 2'b01;
    edges(1);
    chk("ack_clears", {30'd0, event_pending}, 32'd0);
    #1 event_ack = 2'b00;
    edges(8);
    chk("first_repeat", {30'd0, repeat_pulse}, 32'd1);
    #1 event_ack = 2'b01;
    edges(1);
    chk("set_wins_over_ack", {30'd0, event_pending}, 32'd1);
    chk("repeat_one_cycle", {30'd0, repeat_pulse}, 32'd0);
    edges(1);
    chk("ack_no_set_clears", {30'd0, event_pending}, 32'd0);
    #1 event_ack = 2'b00; btn_raw = 2'b11;
    edges(2);
    #1 btn_raw = 2'b10;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      chk("glitch_keeps_pressed", {31'd0, pressed[0]}, 32'd1);
      chk("glitch_no_release", {31'd0, release_pulse[0]}, 32'd0);
    end
    #1 btn_raw = 2'b11;
    edges(6);
    chk("release_latency_early", {31'd0, pressed[0]}, 32'd1);
    edges(1);
    chk("release_fall", {31'd0, pressed[0]}, 32'd0);
    chk("release_pulse", {30'd0, release_pulse}, 32'd1);
    edges(1);
    chk("release_pulse_one_cycle", {30'd0, release_pulse}, 32'd0);
    #1 event_ack = 2'b11;
    edges(1);
    #1 event_ack = 2'b00; btn_raw = 2'b10;
    edges(3);
    #1 btn_raw = 2'b11;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      chk("bounce_pressed", {31'd0, pressed[0]}, 32'd0);
      chk("bounce_press_pulse", {31'd0, press_pulse[0]}, 32'd0);
      chk("bounce_pending", {31'd0, event_pending[0]}, 32'd0);
    end
    #1 btn_raw = 2'b01;
    edges(6);
    chk("ch1_press_early", {31'd0, pressed[1]}, 32'd0);
    for (int k = 0; k <= 30; k++) begin
      edges(1);
      chk("ch1_held", {31'd0, pressed[1]}, 32'd1);
      chk("ch1_repeat_offset", {31'd0, repeat_pulse[1]}, {31'd0, repMask[k]});
      chk("ch1_press_offset", {31'd0, press_pulse[1]}, (k == 0) ? 32'd1 : 32'd0);
    end
    #1 btn_raw = 2'b00;
    edges(9);
    chk("both_held", {30'd0, pressed}, 32'd3);
    chk("both_pending", {30'd0, event_pending}, 32'd3);
    #2 rst_n = 1'b0;
    #1 chkAllZero("async_reset_outputs");
    edges(2);
    #1 rst_n = 1'b1;
    edges(6);
    chk("repress_early", {30'd0, pressed}, 32'd0);
    edges(1);
    chk("repress_pressed", {30'd0, pressed}, 32'd3);
    chk("repress_pulse", {30'd0, press_pulse}, 32'd3);

    left[0] = 0; left[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      edges(1);
      #1;
      for (int c = 0; c < 2; c++) begin
        if (left[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          r = $urandom_range(0, 2);
          left[c] = (r == 0) ? $urandom_range(1, 4) : (r == 1) ? $urandom_range(5, 9) : $urandom_range(15, 45);
        end
        left[c]--;
      end
      event_ack = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
    end
    edges(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
